// File: rtl/cache_read_arbiter.sv
// Two-requester read arbiter in front of a single-outstanding cache read port.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority to requester 1.
module cache_read_arbiter (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         flush,
    input  logic         req0_valid,
    input  logic [31:0]  req0_addr,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [31:0]  req1_addr,
    output logic         req1_ready,
    output logic         r_valid,
    output logic [31:0]  ReadAddr,
    input  logic         cache_ready,
    input  logic         cache_resp_valid,
    input  logic [108:0] Cache_result,
    output logic         resp0_valid,
    output logic         resp1_valid,
    output logic [108:0] resp_data,
    output logic [31:0]  resp_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner;
    logic        last_grant;
    logic [31:0] saved_addr;
    logic        sel;
    logic [31:0] sel_addr;
    logic        grant;

    // With no requester valid the choice is irrelevant (r_valid is 0), so park on last_grant.
    always_comb begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        if (req0_valid && req1_valid)
            sel = ~last_grant;
        else if (req0_valid || req1_valid)
            sel = req1_valid;
        else
            sel = last_grant;
`else
        sel = (req0_valid || req1_valid) ? req1_valid : last_grant;
`endif
        sel_addr = sel ? req1_addr : req0_addr;
    end

    assign grant = r_valid && cache_ready;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            owner      <= 1'b0;
            saved_addr <= '0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner      <= sel;
                saved_addr <= sel_addr;
                last_grant <= sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY: begin
                if (cache_resp_valid)
                    state_nxt = IDLE;
                else if (flush)
                    state_nxt = DRAIN;
            end
            DRAIN:   if (cache_resp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        r_valid     = 1'b0;
        ReadAddr    = '0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        resp_data   = '0;
        resp_addr   = '0;
        case (state)
            IDLE: begin
                if (RESET && !flush && (req0_valid || req1_valid)) begin
                    r_valid    = 1'b1;
                    ReadAddr   = sel_addr;
                    req0_ready = cache_ready && !sel;
                    req1_ready = cache_ready && sel;
                end
            end
            BUSY: begin
                if (RESET && cache_resp_valid && !flush) begin
                    resp0_valid = !owner;
                    resp1_valid = owner;
                    resp_data   = Cache_result;
                    resp_addr   = saved_addr;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_read_arbiter.sv
// Directed bench for cache_read_arbiter with a transaction-level reference model.
module tb_cache_read_arbiter;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         flush;
    logic         req0_valid;
    logic [31:0]  req0_addr;
    logic         req0_ready;
    logic         req1_valid;
    logic [31:0]  req1_addr;
    logic         req1_ready;
    logic         r_valid;
    logic [31:0]  ReadAddr;
    logic         cache_ready;
    logic         cache_resp_valid;
    logic [108:0] Cache_result;
    logic         resp0_valid;
    logic         resp1_valid;
    logic [108:0] resp_data;
    logic [31:0]  resp_addr;

    int total = 0;
    int bad   = 0;

    cache_read_arbiter dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .flush            (flush),
        .req0_valid       (req0_valid),
        .req0_addr        (req0_addr),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_addr        (req1_addr),
        .req1_ready       (req1_ready),
        .r_valid          (r_valid),
        .ReadAddr         (ReadAddr),
        .cache_ready      (cache_ready),
        .cache_resp_valid (cache_resp_valid),
        .Cache_result     (Cache_result),
        .resp0_valid      (resp0_valid),
        .resp1_valid      (resp1_valid),
        .resp_data        (resp_data),
        .resp_addr        (resp_addr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [108:0] act, input logic [108:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pend 0 = nothing outstanding, 1 = read awaiting response, 2 = read to discard.
    int          pend   = 0;
    logic        m_own  = 1'b0;
    logic [31:0] m_addr = '0;
    logic        m_last = 1'b1;

    always begin
        int          n_pend;
        logic        n_own, n_last, win, e_rv, e_r0, e_r1, e_resp;
        logic [31:0] n_addr;
        @(negedge CLK);
        if (req0_valid && req1_valid) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            win = (m_last == 1'b0);
`else
            win = 1'b1;
`endif
        end else begin
            win = req1_valid;
        end
        e_rv   = RESET && pend == 0 && !flush && (req0_valid || req1_valid);
        e_r0   = e_rv && cache_ready && !win;
        e_r1   = e_rv && cache_ready && win;
        e_resp = RESET && pend == 1 && cache_resp_valid && !flush;

        chk("r_valid", r_valid, e_rv);
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("resp0_valid", resp0_valid, e_resp && !m_own);
        chk("resp1_valid", resp1_valid, e_resp && m_own);
        if (e_rv)
            chk("ReadAddr", ReadAddr, win ? req1_addr : req0_addr);
        if (e_resp) begin
            chk("resp_data", resp_data, Cache_result);
            chk("resp_addr", resp_addr, m_addr);
        end
        if (!RESET) begin
            chk("rst_ReadAddr", ReadAddr, '0);
            chk("rst_resp_data", resp_data, '0);
            chk("rst_resp_addr", resp_addr, '0);
        end

        n_pend = pend; n_own = m_own; n_addr = m_addr; n_last = m_last;
        if (!RESET) begin
            n_pend = 0; n_own = 1'b0; n_addr = '0; n_last = 1'b1;
        end else if (e_r0 || e_r1) begin
            n_pend = 1; n_own = win; n_addr = win ? req1_addr : req0_addr; n_last = win;
        end else if (pend == 1) begin
            if (cache_resp_valid) n_pend = 0;
            else if (flush)       n_pend = 2;
        end else if (pend == 2 && cache_resp_valid) begin
            n_pend = 0;
        end
        @(posedge CLK);
        pend = n_pend; m_own = n_own; m_addr = n_addr; m_last = n_last;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
    endtask

    initial begin
        logic [3:0] grants;
        logic [3:0] exp_grants;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        exp_grants = 4'b1010;
`else
        exp_grants = 4'b1111;
`endif
        flush = 0; req0_valid = 0; req0_addr = '0; req1_valid = 0; req1_addr = '0;
        cache_ready = 0; cache_resp_valid = 0; Cache_result = '0;
        grants = '0;
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("lit_reset_rvalid", r_valid, 1'b0);
        tick();
        tick();
        RESET = 1'b1;

        // Single read from requester 0
        req0_valid = 1; req0_addr = 32'h0000_1000; cache_ready = 1;
        @(negedge CLK);
        chk("lit_single_ready0", req0_ready, 1'b1);
        chk("lit_single_addr", ReadAddr, 32'h0000_1000);
        tick();
        req0_valid = 0; cache_resp_valid = 1; Cache_result = 109'h1;
        @(negedge CLK);
        chk("lit_single_resp0", resp0_valid, 1'b1);
        chk("lit_single_raddr", resp_addr, 32'h0000_1000);
        chk("lit_single_rdata", resp_data, 109'h1);
        tick();
        cache_resp_valid = 0;
        @(negedge CLK);
        chk("lit_single_resp0_off", resp0_valid, 1'b0);

        // Contention after a fresh reset
        do_reset();
        req0_valid = 1; req0_addr = 32'h0000_2000;
        req1_valid = 1; req1_addr = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("lit_cont_onehot", req0_ready ^ req1_ready, 1'b1);
            grants[i] = req1_ready;
            tick();
            cache_resp_valid = 1; Cache_result = 109'(i + 16);
            tick();
            cache_resp_valid = 0;
        end
        chk("lit_cont_grants", grants, exp_grants);
        req0_valid = 0; req1_valid = 0;

        // Cache stall with requester 1
        req1_valid = 1; req1_addr = 32'h0000_4000; cache_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("lit_stall_rvalid", r_valid, 1'b1);
            chk("lit_stall_addr", ReadAddr, 32'h0000_4000);
            chk("lit_stall_ready1", req1_ready, 1'b0);
            tick();
        end
        cache_ready = 1;
        @(negedge CLK);
        chk("lit_stall_grant", req1_ready, 1'b1);
        tick();
        req1_valid = 0; cache_resp_valid = 1; Cache_result = {13'h1abc, 96'hdead_beef_0123_4567_89ab_cdef};
        @(negedge CLK);
        chk("lit_stall_resp1", resp1_valid, 1'b1);
        tick();
        cache_resp_valid = 0;

        // Flush while busy, response arrives later during drain
        req0_valid = 1; req0_addr = 32'h0000_5000;
        tick();
        req0_valid = 0; flush = 1;
        tick();
        flush = 0; req1_valid = 1; req1_addr = 32'h0000_6000;
        @(negedge CLK);
        chk("lit_drain_rvalid", r_valid, 1'b0);
        tick();
        cache_resp_valid = 1; Cache_result = 109'h55;
        @(negedge CLK);
        chk("lit_drain_resp0", resp0_valid, 1'b0);
        tick();
        cache_resp_valid = 0;
        @(negedge CLK);
        chk("lit_after_drain_grant", req1_ready, 1'b1);
        tick();
        req1_valid = 0; cache_resp_valid = 1; Cache_result = 109'h66;
        @(negedge CLK);
        chk("lit_after_drain_resp1", resp1_valid, 1'b1);
        chk("lit_after_drain_addr", resp_addr, 32'h0000_6000);
        tick();
        cache_resp_valid = 0;

        // Flush coincident with response
        req0_valid = 1; req0_addr = 32'h0000_7000;
        tick();
        req0_valid = 0; flush = 1; cache_resp_valid = 1; Cache_result = 109'h77;
        @(negedge CLK);
        chk("lit_coinc_resp0", resp0_valid, 1'b0);
        tick();
        flush = 0; cache_resp_valid = 0; req0_valid = 1; req0_addr = 32'h0000_7100;
        @(negedge CLK);
        chk("lit_coinc_idle_grant", req0_ready, 1'b1);
        tick();
        req0_valid = 0;

        // Reset while busy; late response must be ignored
        RESET = 1'b0;
        @(negedge CLK);
        chk("lit_midrst_rvalid", r_valid, 1'b0);
        chk("lit_midrst_resp0", resp0_valid, 1'b0);
        tick();
        RESET = 1'b1; cache_resp_valid = 1; Cache_result = 109'h88;
        @(negedge CLK);
        chk("lit_late_resp0", resp0_valid, 1'b0);
        chk("lit_late_resp1", resp1_valid, 1'b0);
        tick();
        cache_resp_valid = 0;

        // Flush in IDLE blocks grants
        req0_valid = 1; req0_addr = 32'h0000_8000; flush = 1;
        @(negedge CLK);
        chk("lit_idleflush_rvalid", r_valid, 1'b0);
        chk("lit_idleflush_ready0", req0_ready, 1'b0);
        tick();
        flush = 0;
        @(negedge CLK);
        chk("lit_postflush_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 0; cache_resp_valid = 1; Cache_result = 109'h99;
        tick();
        cache_resp_valid = 0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_read_arbiter.md
CACHE_READ_ARBITER -- requirements
Module: cache_read_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  rising-edge clock; RESET  in  1  synchronous, active-low reset.
REQ-002 SHALL have port: flush  in  1  pipeline flush; aborts the outstanding read and blocks grants.
REQ-003 SHALL have ports: req0_valid  in  1  / req0_addr  in  32  / req0_ready  out  1  (requester 0, instruction fetch).
REQ-004 SHALL have ports: req1_valid  in  1  / req1_addr  in  32  / req1_ready  out  1  (requester 1, data load).
REQ-005 SHALL have ports: r_valid  out  1  / ReadAddr  out  32  / cache_ready  in  1  (cache read request port).
REQ-006 SHALL have ports: cache_resp_valid  in  1  / Cache_result  in  109  (cache response, already registered by the cache pipeline stage).
REQ-007 SHALL have ports: resp0_valid  out  1 / resp1_valid  out  1 / resp_data  out  109 / resp_addr  out  32.
REQ-008 Clock and reset SHALL be exactly: one clock; reset is synchronous and active-low.

Function
REQ-009 States SHALL be IDLE, BUSY and DRAIN, encoded in 2 bits; any unused encoding SHALL go to IDLE on the next edge.
REQ-010 In IDLE with flush=0, the arbiter SHALL select one valid requester, drive r_valid=1 and ReadAddr=selected addr combinationally.
REQ-011 Handshake SHALL complete when r_valid&&cache_ready; the winner's reqN_ready SHALL be 1 only in that cycle, and the loser's ready SHALL be 0.
REQ-012 On completion, the block SHALL register owner and ReadAddr into saved_addr and go to BUSY; with no completion it SHALL stay in IDLE, and requesters SHALL hold valid and addr stable.
REQ-013 In BUSY, r_valid SHALL be 0, and at most one read SHALL be outstanding.
REQ-014 In BUSY with cache_resp_valid=1 and flush=0, respN_valid (N=owner) SHALL be 1 for that cycle, with resp_data=Cache_result and resp_addr=saved_addr; the state SHALL go to IDLE.
REQ-015 The response cycle SHALL NOT also issue a new grant; back-to-back reads SHALL therefore be spaced at least 2 cycles apart.
REQ-016 In BUSY with flush=1 and cache_resp_valid=0, the next state SHALL be DRAIN.
REQ-017 In BUSY with flush=1 and cache_resp_valid=1, the response SHALL be discarded and the next state SHALL be IDLE.
REQ-018 In DRAIN, resp0_valid and resp1_valid SHALL be 0, r_valid SHALL be 0, and cache_resp_valid SHALL return the state to IDLE.
REQ-019 In IDLE with flush=1, r_valid, req0_ready and req1_ready SHALL all be 0.
REQ-020 resp_data and resp_addr SHALL be don't-care when both respN_valid outputs are 0; the bench SHALL NOT check them then.
REQ-021 A cache_resp_valid arriving in IDLE SHALL be ignored (no respN_valid).

Reset
REQ-022 With RESET=0 at a clock edge: state=IDLE, owner=0, saved_addr=0, last_grant=1.
REQ-023 During and after reset, outputs SHALL be r_valid=0, ReadAddr=0, req0_ready=0, req1_ready=0, resp0_valid=0, resp1_valid=0, resp_data=0 and resp_addr=0 until the first grant or response.
REQ-024 Reset in BUSY or DRAIN SHALL drop the outstanding read; a later cache_resp_valid SHALL be ignored per REQ-021.

Configuration
REQ-025 Macro CACHE_ARB_ROUND_ROBIN_EN defined: when both requesters are valid, grant SHALL go to the requester not equal to last_grant; last_grant SHALL update on each completed handshake.
REQ-026 Macro CACHE_ARB_ROUND_ROBIN_EN undefined: requester 1 SHALL have fixed priority; last_grant SHALL still exist but SHALL not affect selection.

Verification
REQ-027 Single read: req0_valid=1, req0_addr=0x0000_1000, cache_ready=1, response 1 cycle later with Cache_result=109'h1 -> resp0_valid=1 for 1 cycle, resp_addr=0x0000_1000.
REQ-028 Contention with the macro defined: both requesters held valid for 4 reads -> grants 0,1,0,1 after reset; with the macro undefined -> grants 1,1,1,1.
REQ-029 Cache stall: cache_ready=0 for 3 cycles with req1_valid=1 -> r_valid stays 1, ReadAddr stable, req1_ready=0, then one grant when cache_ready=1.
REQ-030 Flush in BUSY: flush pulses 1 cycle before the response -> no respN_valid, state returns to IDLE on cache_resp_valid, next request granted normally.
REQ-031 Flush coincident with response -> response discarded, IDLE next cycle; RESET=0 mid-BUSY -> all outputs 0, late cache_resp_valid ignored.
